// File: rtl/bitbrick_pkg.sv
// Shared definitions for the BitBrick product accumulator: FSM states,
// mode encodings and default widths.
package bitbrick_pkg;

    localparam int ACC_W_DEF = 16;
    localparam int LEN_W_DEF = 8;

    localparam logic MODE_4B = 1'b1;
    localparam logic MODE_2B = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/bitbrick_sat_add.sv
// One accumulator lane step: extend an 8-bit or 4-bit product, add it to the
// running sum and clamp to the signed or unsigned lane range.
module bitbrick_sat_add #(
    parameter int ACC_W = 16
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [7:0]       op_i,
    input  logic             narrow_i,
    input  logic             signed_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             ovf_o
);

    logic             ext_bit;
    logic [ACC_W:0]   acc_x;
    logic [ACC_W:0]   op_x;
    logic [ACC_W:0]   sum_x;

    always_comb begin
        ext_bit = 1'b0;
        op_x    = '0;
        if (narrow_i) begin
            ext_bit = signed_i & op_i[3];
            op_x    = {{(ACC_W-3){ext_bit}}, op_i[3:0]};
        end else begin
            ext_bit = signed_i & op_i[7];
            op_x    = {{(ACC_W-7){ext_bit}}, op_i};
        end
        acc_x = {signed_i & acc_i[ACC_W-1], acc_i};
        sum_x = acc_x + op_x;
    end

    // One guard bit is enough: a single add can leave the lane range by at most one bit.
    always_comb begin
        ovf_o = 1'b0;
        sum_o = sum_x[ACC_W-1:0];
        if (signed_i) begin
            ovf_o = sum_x[ACC_W] ^ sum_x[ACC_W-1];
            if (ovf_o) begin
                sum_o = sum_x[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                     : {1'b0, {(ACC_W-1){1'b1}}};
            end
        end else begin
            ovf_o = sum_x[ACC_W];
            if (ovf_o) begin
                sum_o = '1;
            end
        end
    end

endmodule

// File: rtl/bitbrick_accumulator.sv
// Accumulates K BitBrick products into two saturating lanes and holds the
// result until the consumer takes it.
module bitbrick_accumulator
    import bitbrick_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_mode,
    input  logic             cfg_signed,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_p,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc0,
    output logic [ACC_W-1:0] out_acc1,
    output logic [1:0]       out_sat,
    output logic [1:0]       dbg_state
);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   last_q, last_d;
    logic               mode_q, mode_d;
    logic               sgn_q, sgn_d;
    logic [ACC_W-1:0]   acc0_q, acc0_d;
    logic [ACC_W-1:0]   acc1_q, acc1_d;
    logic [1:0]         sat_q, sat_d;

    logic               beat;
    logic [ACC_W-1:0]   sum0, sum1;
    logic               ovf0, ovf1;

    // in_p is accepted on in_valid && in_ready; results leave on out_valid && out_ready.
    // Both ready/valid outputs decode only the registered state.
    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_acc0  = acc0_q;
    assign out_acc1  = acc1_q;
    assign out_sat   = sat_q;
    assign dbg_state = state_q;

    assign beat = in_valid && in_ready;

    bitbrick_sat_add #(.ACC_W(ACC_W)) u_lane0 (
        .acc_i    (acc0_q),
        .op_i     (in_p),
        .narrow_i (mode_q == MODE_2B),
        .signed_i (sgn_q),
        .sum_o    (sum0),
        .ovf_o    (ovf0)
    );

    bitbrick_sat_add #(.ACC_W(ACC_W)) u_lane1 (
        .acc_i    (acc1_q),
        .op_i     ({4'b0000, in_p[7:4]}),
        .narrow_i (1'b1),
        .signed_i (sgn_q),
        .sum_o    (sum1),
        .ovf_o    (ovf1)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        mode_d  = mode_q;
        sgn_d   = sgn_q;
        acc0_d  = acc0_q;
        acc1_d  = acc1_q;
        sat_d   = sat_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACC;
                    // A zero length still runs one beat.
                    last_d  = (cfg_len == '0) ? '0 : cfg_len - LEN_W'(1);
                    mode_d  = cfg_mode;
                    sgn_d   = cfg_signed;
                    cnt_d   = '0;
                    acc0_d  = '0;
                    acc1_d  = '0;
                    sat_d   = 2'b00;
                end
            end
            ACC: begin
                if (beat) begin
                    acc0_d   = sum0;
                    sat_d[0] = sat_q[0] | ovf0;
                    if (mode_q == MODE_2B) begin
                        acc1_d   = sum1;
                        sat_d[1] = sat_q[1] | ovf1;
                    end
                    if (cnt_q == last_q) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= '0;
            mode_q  <= 1'b0;
            sgn_q   <= 1'b0;
            acc0_q  <= '0;
            acc1_q  <= '0;
            sat_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            mode_q  <= mode_d;
            sgn_q   <= sgn_d;
            acc0_q  <= acc0_d;
            acc1_q  <= acc1_d;
            sat_q   <= sat_d;
        end
    end

endmodule

// File: tb/tb_bitbrick_accumulator.sv
// Directed bench for bitbrick_accumulator: a table of jobs with hand-computed
// results plus hand-written back-pressure, reset and priority sequences.
module tb_bitbrick_accumulator;
    import bitbrick_pkg::*;

    logic        clock, reset, start;
    logic [7:0]  cfg_len;
    logic        cfg_mode, cfg_signed;
    logic        in_valid, out_ready;
    logic [7:0]  in_p;

    logic        in_ready_a, busy_a, out_valid_a;
    logic [15:0] acc0_a, acc1_a;
    logic [1:0]  sat_a, dbg_a;

    logic        in_ready_b, busy_b, out_valid_b;
    logic [9:0]  acc0_b, acc1_b;
    logic [1:0]  sat_b, dbg_b;

    int n_cmp = 0;
    int n_err = 0;

    bitbrick_accumulator #(.ACC_W(16), .LEN_W(8)) dut16 (
        .clock(clock), .reset(reset), .start(start), .cfg_len(cfg_len),
        .cfg_mode(cfg_mode), .cfg_signed(cfg_signed), .in_valid(in_valid),
        .in_ready(in_ready_a), .in_p(in_p), .busy(busy_a), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_acc0(acc0_a), .out_acc1(acc1_a),
        .out_sat(sat_a), .dbg_state(dbg_a)
    );

    bitbrick_accumulator #(.ACC_W(10), .LEN_W(8)) dut10 (
        .clock(clock), .reset(reset), .start(start), .cfg_len(cfg_len),
        .cfg_mode(cfg_mode), .cfg_signed(cfg_signed), .in_valid(in_valid),
        .in_ready(in_ready_b), .in_p(in_p), .busy(busy_b), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_acc0(acc0_b), .out_acc1(acc1_b),
        .out_sat(sat_b), .dbg_state(dbg_b)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic        mode;
        logic        sgn;
        logic [7:0]  len;
        int          nb;
        logic [63:0] p;   // beat i in byte i
        logic [15:0] e0;
        logic [15:0] e1;
        logic [1:0]  es;
        logic        w10; // check the ACC_W=10 instance
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int idx, input logic mode, input logic sgn, input logic [7:0] len,
                           input int nb, input logic [63:0] p, input logic [15:0] e0,
                           input logic [15:0] e1, input logic [1:0] es, input logic w10);
        vecs[idx].mode = mode;
        vecs[idx].sgn  = sgn;
        vecs[idx].len  = len;
        vecs[idx].nb   = nb;
        vecs[idx].p    = p;
        vecs[idx].e0   = e0;
        vecs[idx].e1   = e1;
        vecs[idx].es   = es;
        vecs[idx].w10  = w10;
    endtask

    task automatic start_job(input logic mode, input logic sgn, input logic [7:0] len);
        @(negedge clock);
        chk("idle_in_ready", {31'd0, in_ready_a}, 32'd0);
        chk("idle_busy", {31'd0, busy_a}, 32'd0);
        start      = 1'b1;
        cfg_mode   = mode;
        cfg_signed = sgn;
        cfg_len    = len;
        @(negedge clock);
        start      = 1'b0;
        cfg_mode   = ~mode;
        cfg_signed = ~sgn;
        cfg_len    = 8'd1;
        chk("acc_in_ready", {31'd0, in_ready_a}, 32'd1);
        chk("acc_busy", {31'd0, busy_a}, 32'd1);
    endtask

    task automatic feed(input logic [7:0] p, input logic gap);
        if (gap) begin
            in_valid = 1'b0;
            in_p     = 8'hFF;
            @(negedge clock);
        end
        in_valid = 1'b1;
        in_p     = p;
        chk("pre_beat_out_valid", {31'd0, out_valid_a}, 32'd0);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        chk("post_out_valid", {31'd0, out_valid_a}, 32'd0);
        chk("post_busy", {31'd0, busy_a}, 32'd0);
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        start_job(v.mode, v.sgn, v.len);
        for (int i = 0; i < v.nb; i++) begin
            feed(v.p[8*i +: 8], (i % 2) == 1);
        end
        chk($sformatf("v%0d_out_valid", idx), {31'd0, out_valid_a}, 32'd1);
        chk($sformatf("v%0d_in_ready", idx), {31'd0, in_ready_a}, 32'd0);
        if (v.w10) begin
            chk($sformatf("v%0d_acc0", idx), {22'd0, acc0_b}, {16'd0, v.e0});
            chk($sformatf("v%0d_acc1", idx), {22'd0, acc1_b}, {16'd0, v.e1});
            chk($sformatf("v%0d_sat", idx), {30'd0, sat_b}, {30'd0, v.es});
        end else begin
            chk($sformatf("v%0d_acc0", idx), {16'd0, acc0_a}, {16'd0, v.e0});
            chk($sformatf("v%0d_acc1", idx), {16'd0, acc1_a}, {16'd0, v.e1});
            chk($sformatf("v%0d_sat", idx), {30'd0, sat_a}, {30'd0, v.es});
        end
        release_result();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; cfg_len = 8'd0; cfg_mode = 1'b0; cfg_signed = 1'b0;
        in_valid = 1'b0; in_p = 8'd0; out_ready = 1'b0;

        set_vec(0, MODE_4B, 1'b1, 8'd3, 3, 64'h0000_0000_0002_40F8, 16'h003A, 16'h0000, 2'b00, 1'b0);
        set_vec(1, MODE_2B, 1'b1, 8'd2, 2, 64'h0000_0000_0000_E23F, 16'h0001, 16'h0001, 2'b00, 1'b0);
        set_vec(2, MODE_4B, 1'b0, 8'd5, 5, 64'h0000_00E1_E1E1_E1E1, 16'h03FF, 16'h0000, 2'b01, 1'b1);
        set_vec(3, MODE_4B, 1'b0, 8'd0, 1, 64'h0000_0000_0000_0007, 16'h0007, 16'h0000, 2'b00, 1'b0);
        set_vec(4, MODE_4B, 1'b1, 8'd5, 5, 64'h0000_0080_8080_8080, 16'h0200, 16'h0000, 2'b01, 1'b1);
        set_vec(5, MODE_2B, 1'b0, 8'd3, 3, 64'h0000_0000_00FF_FFFF, 16'h002D, 16'h002D, 2'b00, 1'b0);
        set_vec(6, MODE_2B, 1'b1, 8'd2, 2, 64'h0000_0000_0000_9797, 16'h000E, 16'hFFF2, 2'b00, 1'b0);
        set_vec(7, MODE_4B, 1'b0, 8'd2, 2, 64'h0000_0000_0000_FFFF, 16'h01FE, 16'h0000, 2'b00, 1'b0);
        set_vec(8, MODE_4B, 1'b0, 8'd6, 6, 64'h0000_00FF_FFFF_FFFF, 16'h03FF, 16'h0000, 2'b01, 1'b1);

        repeat (3) @(negedge clock);
        chk("rst_in_ready", {31'd0, in_ready_a}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid_a}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_state", {30'd0, dbg_a}, 32'd0);
        chk("rst_acc0", {16'd0, acc0_a}, 32'd0);
        chk("rst_acc1", {16'd0, acc1_a}, 32'd0);
        chk("rst_sat", {30'd0, sat_a}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_vec(i);
        end

        // Back-pressure in DONE with an ignored start pulse.
        start_job(MODE_4B, 1'b0, 8'd1);
        feed(8'h05, 1'b0);
        for (int c = 0; c < 3; c++) begin
            chk("hold_out_valid", {31'd0, out_valid_a}, 32'd1);
            chk("hold_in_ready", {31'd0, in_ready_a}, 32'd0);
            chk("hold_acc0", {16'd0, acc0_a}, 32'h5);
            start = (c == 1);
            @(negedge clock);
        end
        start = 1'b0;
        chk("hold_after_start", {31'd0, out_valid_a}, 32'd1);
        chk("hold_after_acc0", {16'd0, acc0_a}, 32'h5);
        release_result();

        // Reset mid-job discards the partial sum.
        start_job(MODE_4B, 1'b0, 8'd4);
        feed(8'h10, 1'b0);
        feed(8'h20, 1'b1);
        chk("partial_acc0", {16'd0, acc0_a}, 32'h30);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midrst_busy", {31'd0, busy_a}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready_a}, 32'd0);
        chk("midrst_out_valid", {31'd0, out_valid_a}, 32'd0);
        chk("midrst_acc0", {16'd0, acc0_a}, 32'd0);
        chk("midrst_acc1", {16'd0, acc1_a}, 32'd0);
        chk("midrst_sat", {30'd0, sat_a}, 32'd0);
        start_job(MODE_4B, 1'b0, 8'd1);
        feed(8'h05, 1'b0);
        chk("newjob_out_valid", {31'd0, out_valid_a}, 32'd1);
        chk("newjob_acc0", {16'd0, acc0_a}, 32'h5);
        release_result();

        // Reset wins over out_ready and start in the same cycle.
        start_job(MODE_4B, 1'b0, 8'd1);
        feed(8'h07, 1'b0);
        reset = 1'b1; out_ready = 1'b1; start = 1'b1;
        @(negedge clock);
        reset = 1'b0; out_ready = 1'b0; start = 1'b0;
        chk("prio_busy", {31'd0, busy_a}, 32'd0);
        chk("prio_out_valid", {31'd0, out_valid_a}, 32'd0);
        chk("prio_acc0", {16'd0, acc0_a}, 32'd0);
        @(negedge clock);
        chk("prio_still_idle", {31'd0, busy_a}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
